// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers for the five-stage MIPS core,
// driven by the hazard unit's stall/flush controls and decode-stage redirects.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 8,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushE,
    input  logic              pcsrcD,
    input  logic [31:0]       pcbranchD,
    input  logic              jumpD,
    input  logic [31:0]       pcjumpD,
    input  logic [31:0]       instrF,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [31:0]       pcF,
    output logic [31:0]       instrD,
    output logic [31:0]       pcplus4D,
    output logic              validD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic              validE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        redirD;
    logic [31:0] pcplus4F;
    logic [31:0] pcNext;

    // A redirect under stallD is dropped: its operands are not forwarded yet.
    assign redirD   = (pcsrcD | jumpD) & ~stallD;
    assign pcplus4F = pcF + 32'd4;

    always_comb begin
        pcNext = pcplus4F;
        if (stallF) begin
            pcNext = pcF;
        end else if (jumpD && !stallD) begin
            pcNext = pcjumpD;
        end else if (redirD) begin
            pcNext = pcbranchD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcF <= RESET_PC;
        end else begin
            pcF <= pcNext;
        end
    end

    // validD/validE mark a stage holding a real instruction; every bubble or
    // killed slot carries all-zero fields with its valid bit low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            pcplus4D <= pcplus4D;
            validD   <= validD;
        end else if (redirD) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else begin
            instrD   <= instrF;
            pcplus4D <= pcplus4F;
            validD   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flushE) begin
            ctrlE  <= '0;
            rsE    <= '0;
            rtE    <= '0;
            rdE    <= '0;
            validE <= 1'b0;
        end else begin
            ctrlE  <= ctrlD;
            rsE    <= rsD;
            rtE    <= rtD;
            rdE    <= rdD;
            validE <= validD;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stallD && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (redirD && redirect_cnt != CNT_MAX) begin
                redirect_cnt <= redirect_cnt + CNT_ONE;
            end
        end
    end

endmodule
